// File: rtl/types_pkg.sv
// Shared datapath types for the computing unit and its front-end loader.
package types;

  localparam int unsigned DATA_TYPE_SIZE = 16;

  typedef logic [DATA_TYPE_SIZE-1:0] data_type;

  typedef enum logic [1:0] {
    TAG_ACT = 2'd0,
    TAG_WGT = 2'd1,
    TAG_OFS = 2'd2,
    TAG_INV = 2'd3
  } loader_tag_t;

  typedef enum logic [1:0] {
    LD_FILL   = 2'd0,
    LD_ISSUE  = 2'd1,
    LD_UPDATE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/cu_input_loader.sv
// Word-serial loader: assembles tagged stream words into activation, weight and
// offset rows, pushes them into the computing unit queues and signals weight tiles.
module cu_input_loader
  import types::*;
#(
  parameter int unsigned ACTIVATION_COUNT = 16,
  parameter int unsigned WEIGHT_COUNT     = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  data_type                             s_data_i,
  input  logic [1:0]                           s_tag_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  input  logic                                 cu_rst_busy_i,
  output data_type [0:ACTIVATION_COUNT-1]      activation_o,
  output logic                                 activation_wr_en_o,
  input  logic                                 activation_full_i,
  output data_type [0:WEIGHT_COUNT-1]          weight_o,
  output logic                                 weight_wr_en_o,
  input  logic                                 weight_full_i,
  output data_type [0:WEIGHT_COUNT-1]          offset_o,
  output logic                                 offset_wr_en_o,
  input  logic                                 offset_full_i,
  output logic                                 weight_update_o,
  input  logic                                 weight_update_busy_i,
  output logic                                 error_o
);

  localparam int unsigned MAX_COUNT = (ACTIVATION_COUNT > WEIGHT_COUNT) ? ACTIVATION_COUNT : WEIGHT_COUNT;
  localparam int unsigned WCNT_W    = $clog2(MAX_COUNT) + 1;
  localparam int unsigned WROW_W    = $clog2(ACTIVATION_COUNT) + 1;

  loader_state_t                     state_q, state_d;
  data_type [0:MAX_COUNT-1]          row_q, row_d;
  logic [WCNT_W-1:0]                 word_cnt_q, word_cnt_d;
  logic [WROW_W-1:0]                 wrow_cnt_q, wrow_cnt_d;
  loader_tag_t                       row_tag_q, row_tag_d;
  logic                              error_q, error_d;
  data_type [0:ACTIVATION_COUNT-1]   act_q, act_d;
  data_type [0:WEIGHT_COUNT-1]       wgt_q, wgt_d;
  data_type [0:WEIGHT_COUNT-1]       ofs_q, ofs_d;
  logic                              act_wr_q, act_wr_d;
  logic                              wgt_wr_q, wgt_wr_d;
  logic                              ofs_wr_q, ofs_wr_d;
  logic                              update_q, update_d;

  loader_tag_t       in_tag;
  logic              accept;
  logic              tag_full;
  logic [WCNT_W-1:0] slot;

  function automatic logic [WCNT_W-1:0] row_len(input loader_tag_t t);
    return (t == TAG_ACT) ? WCNT_W'(ACTIVATION_COUNT) : WCNT_W'(WEIGHT_COUNT);
  endfunction

  // Ready is forced low while reset is asserted so every output reads 0.
  assign s_ready_o = (state_q == LD_FILL) && !cu_rst_busy_i && !rst_i;
  assign in_tag    = loader_tag_t'(s_tag_i);
  assign accept    = s_valid_i && s_ready_o;

  always_comb begin
    case (row_tag_q)
      TAG_ACT: tag_full = activation_full_i;
      TAG_WGT: tag_full = weight_full_i;
      TAG_OFS: tag_full = offset_full_i;
      default: tag_full = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= LD_FILL;
      row_q      <= '0;
      word_cnt_q <= '0;
      wrow_cnt_q <= '0;
      row_tag_q  <= TAG_ACT;
      error_q    <= 1'b0;
      act_q      <= '0;
      wgt_q      <= '0;
      ofs_q      <= '0;
      act_wr_q   <= 1'b0;
      wgt_wr_q   <= 1'b0;
      ofs_wr_q   <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      word_cnt_q <= word_cnt_d;
      wrow_cnt_q <= wrow_cnt_d;
      row_tag_q  <= row_tag_d;
      error_q    <= error_d;
      act_q      <= act_d;
      wgt_q      <= wgt_d;
      ofs_q      <= ofs_d;
      act_wr_q   <= act_wr_d;
      wgt_wr_q   <= wgt_wr_d;
      ofs_wr_q   <= ofs_wr_d;
      update_q   <= update_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    word_cnt_d = word_cnt_q;
    wrow_cnt_d = wrow_cnt_q;
    row_tag_d  = row_tag_q;
    error_d    = error_q;
    act_d      = act_q;
    wgt_d      = wgt_q;
    ofs_d      = ofs_q;
    act_wr_d   = 1'b0;
    wgt_wr_d   = 1'b0;
    ofs_wr_d   = 1'b0;
    update_d   = 1'b0;
    slot       = word_cnt_q;

    case (state_q)
      LD_FILL: begin
        if (accept) begin
          if (in_tag == TAG_INV) begin
            error_d = 1'b1;
          end else begin
            // A tag change abandons the partial row; the new word becomes element 0.
            if ((word_cnt_q != '0) && (in_tag != row_tag_q)) begin
              error_d = 1'b1;
              slot    = '0;
            end
            row_tag_d = in_tag;
            for (int i = 0; i < MAX_COUNT; i++) begin
              if (WCNT_W'(i) == slot) row_d[i] = s_data_i;
            end
            if ((slot + WCNT_W'(1)) == row_len(in_tag)) begin
              word_cnt_d = '0;
              state_d    = LD_ISSUE;
            end else begin
              word_cnt_d = slot + WCNT_W'(1);
            end
          end
        end
      end

      LD_ISSUE: begin
        if (!tag_full && !cu_rst_busy_i) begin
          state_d = LD_FILL;
          case (row_tag_q)
            TAG_ACT: begin
              act_wr_d = 1'b1;
              for (int i = 0; i < ACTIVATION_COUNT; i++) act_d[i] = row_q[i];
            end
            TAG_WGT: begin
              wgt_wr_d   = 1'b1;
              wrow_cnt_d = wrow_cnt_q + WROW_W'(1);
              for (int i = 0; i < WEIGHT_COUNT; i++) wgt_d[i] = row_q[i];
              if ((wrow_cnt_q + WROW_W'(1)) == WROW_W'(ACTIVATION_COUNT)) state_d = LD_UPDATE;
            end
            TAG_OFS: begin
              ofs_wr_d = 1'b1;
              for (int i = 0; i < WEIGHT_COUNT; i++) ofs_d[i] = row_q[i];
            end
            default: state_d = LD_FILL;
          endcase
        end
      end

      LD_UPDATE: begin
        if (!weight_update_busy_i) begin
          update_d   = 1'b1;
          wrow_cnt_d = '0;
          state_d    = LD_FILL;
        end
      end

      default: state_d = LD_FILL;
    endcase
  end

  assign activation_o       = act_q;
  assign weight_o           = wgt_q;
  assign offset_o           = ofs_q;
  assign activation_wr_en_o = act_wr_q;
  assign weight_wr_en_o     = wgt_wr_q;
  assign offset_wr_en_o     = ofs_wr_q;
  assign weight_update_o    = update_q;
  assign error_o            = error_q;

endmodule
